// File: rtl/mem_wb_stage_if.sv
// Data-memory request/response bus between the MEM stage and the data memory.
// The stage side (master) drives a registered request. The memory side (slave)
// answers with read data and an acknowledge.
interface mem_wb_stage_if #(
  parameter int DATA_W = 32
);
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ack;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_rdata,
    input  dmem_ack
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_rdata,
    output dmem_ack
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM stage plus MEM/WB pipeline register.
// Aligned loads and stores run through a three-state access FSM
// (IDLE -> REQ -> DONE), and the EX/MEM register is stalled until DONE.
// Misaligned memory ops are dropped: no request, no register write, and a
// one-cycle error pulse. Non-memory ops pass to writeback in one cycle.
module mem_wb_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemtoReg_mem,
  input  logic              RegWrite_mem,
  input  logic              MemWrite_mem,
  input  logic [DATA_W-1:0] ALUResult_mem,
  input  logic [DATA_W-1:0] MemWriteData_mem,
  input  logic [4:0]        rdAddr_mem,
  mem_wb_stage_if.master    dmem,
  output logic              stall_mem,
  output logic              RegWrite_wb,
  output logic [4:0]        rdAddr_wb,
  output logic [DATA_W-1:0] WriteData_wb,
  output logic              misalign_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] rdata_q;

  logic memop;
  logic misaligned;
  logic go_mem;

  // Force the byte offset to zero, giving a word-aligned bus address.
  function automatic logic [DATA_W-1:0] word_align(input logic [DATA_W-1:0] addr);
    return {addr[DATA_W-1:2], 2'b00};
  endfunction

  // Decode the instruction in EX/MEM, and hold EX/MEM until the access reaches DONE.
  always_comb begin
    memop      = MemtoReg_mem | MemWrite_mem;
    misaligned = memop & (ALUResult_mem[1:0] != 2'b00);
    go_mem     = memop & ~misaligned;
    stall_mem  = rst_n & go_mem & (state != DONE);
  end

  // Access FSM: the request fields are registered and stay frozen while REQ waits for ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_wdata <= '0;
      rdata_q         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (go_mem) begin
            state           <= REQ;
            dmem.dmem_req   <= 1'b1;
            dmem.dmem_we    <= MemWrite_mem;
            dmem.dmem_addr  <= word_align(ALUResult_mem);
            dmem.dmem_wdata <= MemWriteData_mem;
          end
        end
        REQ: begin
          // An ack counts only while our request is up; a stray ack is ignored.
          if (dmem.dmem_req && dmem.dmem_ack) begin
            rdata_q       <= dmem.dmem_rdata;
            dmem.dmem_req <= 1'b0;
            state         <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state         <= IDLE;
          dmem.dmem_req <= 1'b0;
        end
      endcase
    end
  end

  // MEM/WB register: a stalled edge inserts a bubble, and an advancing edge loads the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      RegWrite_wb  <= 1'b0;
      rdAddr_wb    <= '0;
      WriteData_wb <= '0;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= misaligned;
      if (stall_mem) begin
        RegWrite_wb <= 1'b0;
      end else begin
        rdAddr_wb   <= rdAddr_mem;
        // Any memory op (a store as well) reports the word captured on its ack.
        // Only ALU ops forward the ALU result.
        WriteData_wb <= memop ? rdata_q : ALUResult_mem;
        RegWrite_wb  <= RegWrite_mem & (rdAddr_mem != 5'd0) & ~misaligned;
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage. Each instruction is held in EX/MEM while the stage stalls,
// the way the upstream pipeline would hold it. A small memory answers requests
// after a chosen number of wait cycles. Expected writeback values, stall counts
// and request counts come from the instruction-level rules.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemtoReg_mem, RegWrite_mem, MemWrite_mem;
  logic [31:0] ALUResult_mem, MemWriteData_mem;
  logic [4:0]  rdAddr_mem;
  logic        stall_mem, RegWrite_wb, misalign_err;
  logic [4:0]  rdAddr_wb;
  logic [31:0] WriteData_wb;

  mem_wb_stage_if #(.DATA_W(32)) bus ();

  mem_wb_stage #(.DATA_W(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .MemtoReg_mem     (MemtoReg_mem),
    .RegWrite_mem     (RegWrite_mem),
    .MemWrite_mem     (MemWrite_mem),
    .ALUResult_mem    (ALUResult_mem),
    .MemWriteData_mem (MemWriteData_mem),
    .rdAddr_mem       (rdAddr_mem),
    .dmem             (bus),
    .stall_mem        (stall_mem),
    .RegWrite_wb      (RegWrite_wb),
    .rdAddr_wb        (rdAddr_wb),
    .WriteData_wb     (WriteData_wb),
    .misalign_err     (misalign_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Word memory, and the model's view of the last writeback and last captured read word.
  logic [31:0] mem [logic [31:0]];
  logic [31:0] m_rdata;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic mtr, input logic rw, input logic mw,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd);
    MemtoReg_mem     = mtr;
    RegWrite_mem     = rw;
    MemWrite_mem     = mw;
    ALUResult_mem    = alu;
    MemWriteData_mem = wd;
    rdAddr_mem       = rd;
  endtask

  // Present one instruction (the call starts just after a falling edge), serve its memory
  // access with `dly` extra wait cycles, then check what reaches writeback.
  task automatic run_instr(input logic mtr, input logic rw, input logic mw,
                           input logic [31:0] alu, input logic [31:0] wd,
                           input logic [4:0] rd, input int dly, input string tag);
    logic        memop, mis, go;
    logic [31:0] waddr, exp_wd;
    int          stalls, reqc;
    memop  = mtr | mw;
    mis    = memop && (alu[1:0] != 2'b00);
    go     = memop && !mis;
    waddr  = {alu[31:2], 2'b00};
    stalls = 0;
    reqc   = 0;
    drive(mtr, rw, mw, alu, wd, rd);
    bus.dmem_ack   = 1'($urandom_range(0, 1));
    bus.dmem_rdata = $urandom;
    #1;
    while (stall_mem === 1'b1 && stalls < 40) begin
      stalls++;
      if (stalls > 1) begin
        chk({tag, "_bubble_we"}, 32'(RegWrite_wb), 32'd0);
        chk({tag, "_bubble_rd"}, 32'(rdAddr_wb), 32'(m_rd));
        chk({tag, "_bubble_wd"}, WriteData_wb, m_wd);
      end
      if (bus.dmem_req === 1'b1) begin
        reqc++;
        chk({tag, "_addr"}, bus.dmem_addr, waddr);
        chk({tag, "_we"}, 32'(bus.dmem_we), 32'(mw));
        chk({tag, "_wdata"}, bus.dmem_wdata, wd);
        if (reqc > dly) begin
          bus.dmem_ack   = 1'b1;
          bus.dmem_rdata = mem_rd(waddr);
        end else begin
          bus.dmem_ack   = 1'b0;
          bus.dmem_rdata = $urandom;
        end
      end else begin
        bus.dmem_ack   = 1'($urandom_range(0, 1));
        bus.dmem_rdata = $urandom;
      end
      @(posedge clk);
      @(negedge clk);
      #1;
    end
    chk({tag, "_stalls"}, 32'(stalls), go ? 32'(2 + dly) : 32'd0);
    chk({tag, "_reqcycles"}, 32'(reqc), go ? 32'(1 + dly) : 32'd0);
    if (go) begin
      m_rdata = mem_rd(waddr);
      if (mw) mem[waddr] = wd;
    end
    exp_wd = memop ? m_rdata : alu;
    bus.dmem_ack   = 1'($urandom_range(0, 1));
    bus.dmem_rdata = $urandom;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk({tag, "_wb_we"}, 32'(RegWrite_wb), 32'(rw && (rd != 5'd0) && !mis));
    chk({tag, "_wb_rd"}, 32'(rdAddr_wb), 32'(rd));
    chk({tag, "_wb_data"}, WriteData_wb, exp_wd);
    chk({tag, "_misalign"}, 32'(misalign_err), 32'(mis));
    chk({tag, "_req_idle"}, 32'(bus.dmem_req), 32'd0);
    m_rd = rd;
    m_wd = exp_wd;
  endtask

  initial begin
    int waits;
    int kind;
    logic [31:0] a;
    logic rw;

    // Reset with an aligned load already in EX/MEM: no stall may be seen while in reset.
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 5'd7);
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_stall", 32'(stall_mem), 32'd0);
    chk("rst_req", 32'(bus.dmem_req), 32'd0);
    chk("rst_we", 32'(bus.dmem_we), 32'd0);
    chk("rst_addr", bus.dmem_addr, 32'd0);
    chk("rst_wdata", bus.dmem_wdata, 32'd0);
    chk("rst_wb_we", 32'(RegWrite_wb), 32'd0);
    chk("rst_wb_rd", 32'(rdAddr_wb), 32'd0);
    chk("rst_wb_data", WriteData_wb, 32'd0);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    m_rdata = 32'h0;
    m_rd    = 5'd0;
    m_wd    = 32'h0;
    rst_n   = 1'b1;

    // Directed cases.
    mem[32'h100] = 32'hDEAD_BEEF;
    run_instr(1'b0, 1'b1, 1'b0, 32'h0000_1234, 32'h0, 5'd5, 0, "alu");
    run_instr(1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 5'd7, 0, "load");
    run_instr(1'b0, 1'b0, 1'b1, 32'h0000_0204, 32'hA5A5_A5A5, 5'd3, 3, "store");
    run_instr(1'b1, 1'b1, 1'b0, 32'h0000_0204, 32'h0, 5'd4, 1, "loadback");
    run_instr(1'b1, 1'b1, 1'b0, 32'h0000_0102, 32'h0, 5'd6, 0, "misload");
    run_instr(1'b0, 1'b1, 1'b0, 32'h0000_7777, 32'h0, 5'd0, 0, "rd0");
    run_instr(1'b0, 1'b0, 1'b1, 32'h0000_0207, 32'h1111_2222, 5'd2, 0, "misstore");
    run_instr(1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 5'd8, 2, "load2");

    // Reset while the request is outstanding; a late ack must not surface.
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 5'd9);
    bus.dmem_ack = 1'b0;
    waits = 0;
    #1;
    while (bus.dmem_req !== 1'b1 && waits < 10) begin
      waits++;
      @(posedge clk);
      @(negedge clk);
      #1;
    end
    chk("rstreq_reached", 32'(bus.dmem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstreq_stall", 32'(stall_mem), 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rstreq_req", 32'(bus.dmem_req), 32'd0);
    chk("rstreq_addr", bus.dmem_addr, 32'd0);
    chk("rstreq_wb_we", 32'(RegWrite_wb), 32'd0);
    chk("rstreq_wb_data", WriteData_wb, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    rst_n          = 1'b1;
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 32'hBADB_ADBA;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("late_ack_wb_we", 32'(RegWrite_wb), 32'd0);
      chk("late_ack_req", 32'(bus.dmem_req), 32'd0);
    end
    m_rdata = 32'h0;
    m_rd    = 5'd0;
    m_wd    = 32'h0;
    run_instr(1'b1, 1'b1, 1'b0, 32'h0000_0301, 32'h0, 5'd10, 0, "post_rst_misload");
    run_instr(1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 5'd11, 0, "post_rst_load");

    // Randomized instruction mix over a small address window so loads hit earlier stores.
    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 4));
      rw   = 1'($urandom_range(0, 1));
      a    = 32'h0000_0200 + (32'($urandom_range(0, 7)) << 2);
      case (kind)
        0: run_instr(1'b0, rw, 1'b0, $urandom, $urandom, 5'($urandom_range(0, 31)), 0, "rnd_alu");
        1: run_instr(1'b1, rw, 1'b0, a, $urandom, 5'($urandom_range(0, 31)),
                     int'($urandom_range(0, 3)), "rnd_load");
        2: run_instr(1'b0, rw, 1'b1, a, $urandom, 5'($urandom_range(0, 31)),
                     int'($urandom_range(0, 3)), "rnd_store");
        default: run_instr(1'b1, rw, 1'($urandom_range(0, 1)), a + 32'($urandom_range(1, 3)),
                           $urandom, 5'($urandom_range(0, 31)), 0, "rnd_mis");
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
